// File: rtl/bin2dec_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Also holds the leading-zero blanking helper used when LEADING_ZERO_BLANK_EN is defined.
package bin2dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [3:0]  DIGIT_OFF       = 4'hF;
  localparam int          DEFAULT_MAX_VAL = 9999;
  localparam logic [15:0] SAT_CODE        = 16'h9999;

  // Blank zero digits from D4 downward until the first nonzero one; D1 always stays numeric.
  function automatic logic [15:0] blank_leading_zeros(input logic [15:0] bcd);
    logic [15:0] res;
    logic        lead;
    res  = bcd;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && (bcd[4*i +: 4] == 4'd0)) res[4*i +: 4] = DIGIT_OFF;
      else                                 lead = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2dec_digits_adj.sv
// One BCD digit of the double-dabble correction: digits of 5 or more get +3
// before the shift so that the doubled digit carries correctly into the next one.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2dec_digits.sv
// Sequential binary-to-BCD converter (shift-and-add-3) producing {D4,D3,D2,D1} digit codes.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (D1 is never blanked).
module bin2dec_digits
  import bin2dec_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = DEFAULT_MAX_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      decs,
  output logic             overflow
);

  localparam int SR_W = 16 + BIN_W;

  state_e            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic [15:0]       decs_q, decs_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic [15:0]       bcd_adj;
  logic [15:0]       bcd_res;
  logic [15:0]       display;

  for (genvar g = 0; g < 4; g++) begin : gen_adj
    bcd_digit_adj u_adj (
      .digit_i (sr_q[BIN_W + 4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  assign bcd_res = sr_q[SR_W-1:BIN_W];

`ifdef LEADING_ZERO_BLANK_EN
  assign display = blank_leading_zeros(bcd_res);
`else
  assign display = bcd_res;
`endif

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    decs_d  = decs_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {16'h0000, bin};
          sat_d   = (32'(bin) > 32'(MAX_VAL));
          cnt_d   = 5'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Adjust the BCD digits, then shift the whole BCD:bin register left by one.
        sr_d  = {bcd_adj[14:0], sr_q[BIN_W-1:0], 1'b0};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = FINISH;
      end
      FINISH: begin
        decs_d  = sat_q ? SAT_CODE : display;
        ovf_d   = sat_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      decs_q  <= {4{DIGIT_OFF}};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      decs_q  <= decs_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign decs     = decs_q;
  assign overflow = ovf_q;

endmodule
